// File: rtl/debounce_pkg.sv
// Shared timing defaults for the push-button conditioners, derived from the
// 50 MHz board clock.
package debounce_pkg;

  localparam int CLK_HZ         = 50_000_000;
  localparam int DB_STABLE_5MS  = CLK_HZ / 200;
  localparam int DB_LONG_500MS  = CLK_HZ / 2;
  localparam int DB_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    EDGE_NONE,
    EDGE_RISE,
    EDGE_FALL
  } edgeKind_t;

endpackage

// File: rtl/debounce_chan.sv
// One button channel: synchroniser, stable-time debounce, and press/release/
// long-press strobes with a held level.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int STABLE      = DB_STABLE_5MS,
  parameter int LONG        = DB_LONG_500MS,
  parameter int SYNC_STAGES = DB_SYNC_STAGES,
  parameter int ACTIVE_LOW  = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btnIn,
  output logic btnOut,
  output logic btnPress,
  output logic btnRelease,
  output logic btnLong,
  output logic btnHeld
);

  localparam int DW = $clog2(STABLE);
  localparam int HW = $clog2(LONG);
  localparam logic [DW-1:0] DMAX = DW'(STABLE - 1);
  localparam logic [HW-1:0] HMAX = HW'(LONG - 1);
  localparam logic IDLE = (ACTIVE_LOW != 0);

  logic [SYNC_STAGES-1:0] syncQ;
  logic                   s;
  logic [DW-1:0]          dcnt;
  logic [HW-1:0]          hcnt;
  edgeKind_t              kind;
  logic                   longHit;

  // Reset loads the idle pin level so a released button never looks like a change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      syncQ <= {SYNC_STAGES{IDLE}};
    end else begin
      syncQ <= {syncQ[SYNC_STAGES-2:0], btnIn};
    end
  end

  assign s = syncQ[SYNC_STAGES-1] ^ IDLE;

  // A falling level wins over a long-press that would land on the same edge.
  always_comb begin
    kind    = EDGE_NONE;
    longHit = 1'b0;
    if ((s != btnOut) && (dcnt == DMAX)) begin
      kind = btnOut ? EDGE_FALL : EDGE_RISE;
    end
    if (btnOut && (kind != EDGE_FALL) && (hcnt == HMAX) && !btnHeld) begin
      longHit = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btnOut     <= 1'b0;
      btnPress   <= 1'b0;
      btnRelease <= 1'b0;
      btnLong    <= 1'b0;
      btnHeld    <= 1'b0;
      dcnt       <= '0;
      hcnt       <= '0;
    end else begin
      btnPress   <= (kind == EDGE_RISE);
      btnRelease <= (kind == EDGE_FALL);
      btnLong    <= longHit;

      if (kind != EDGE_NONE) begin
        btnOut <= ~btnOut;
        dcnt   <= '0;
      end else if (s != btnOut) begin
        dcnt <= dcnt + 1'b1;
      end else begin
        dcnt <= '0;
      end

      // hcnt parks at its threshold; btnHeld keeps btnLong from repeating.
      if (kind == EDGE_FALL) begin
        hcnt    <= '0;
        btnHeld <= 1'b0;
      end else if (btnOut) begin
        if (hcnt != HMAX) begin
          hcnt <= hcnt + 1'b1;
        end
        if (longHit) begin
          btnHeld <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/debounce_bank.sv
// Bank of N independent button conditioners; the top level only slices buses.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int N           = 4,
  parameter int STABLE      = DB_STABLE_5MS,
  parameter int LONG        = DB_LONG_500MS,
  parameter int SYNC_STAGES = DB_SYNC_STAGES,
  parameter int ACTIVE_LOW  = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] btnIn,
  output logic [N-1:0] btnOut,
  output logic [N-1:0] btnPress,
  output logic [N-1:0] btnRelease,
  output logic [N-1:0] btnLong,
  output logic [N-1:0] btnHeld
);

  for (genvar i = 0; i < N; i++) begin : gChan
    debounce_chan #(
      .STABLE     (STABLE),
      .LONG       (LONG),
      .SYNC_STAGES(SYNC_STAGES),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) uChan (
      .clk       (clk),
      .rst_n     (rst_n),
      .btnIn     (btnIn[i]),
      .btnOut    (btnOut[i]),
      .btnPress  (btnPress[i]),
      .btnRelease(btnRelease[i]),
      .btnLong   (btnLong[i]),
      .btnHeld   (btnHeld[i])
    );
  end

endmodule

// File: doc/debounce_bank.md
# debounce_bank

Parametrised bank of independent push-button conditioners for the board's button inputs. Each channel synchronises its raw pin, applies a stable-time debounce, and produces a clean level plus one-cycle press/release/long-press strobes. It replaces the fixed four-channel level-only debouncer wrapper and feeds the user-interface control FSMs directly.

## Interface
- N, 4: number of channels.
- STABLE, 250000: consecutive cycles a changed input must hold before it is accepted (5 ms at 50 MHz); must be ≥ 2.
- LONG, 25000000: cycles `btnOut` must stay high before a long press is flagged (0.5 s at 50 MHz); must be ≥ 2.
- SYNC_STAGES, 2: synchroniser flops per channel; must be ≥ 2.
- ACTIVE_LOW, 0: 1 means a pressed pin reads 0. All outputs are active-high regardless.
- clk  in  1  single system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- btnIn  in  N  raw asynchronous button pins.
- btnOut  out  N  debounced level; 1 = pressed.
- btnPress  out  N  one-cycle pulse on each accepted press.
- btnRelease  out  N  one-cycle pulse on each accepted release.
- btnLong  out  N  one-cycle pulse when a press has lasted LONG cycles.
- btnHeld  out  N  level; 1 from the `btnLong` pulse until release.

## Operation
- Channels are fully independent; the per-channel behaviour below applies to every bit.
- **Reset:**
  - Synchroniser flops load the idle pin level (ACTIVE_LOW ? 1 : 0).
  - Debounce and hold counters clear to 0.
  - All outputs are 0.
  - Asserting rst_n mid-count discards the count; no pulse is emitted.
- **Normalisation:** `s` = last synchroniser stage XOR ACTIVE_LOW.
- **Debounce:**
  - `s != btnOut` and `dcnt < STABLE-1`: increment `dcnt`.
  - `s != btnOut` and `dcnt == STABLE-1`: toggle `btnOut`, clear `dcnt`, and pulse `btnPress` (rising) or `btnRelease` (falling) at the same edge.
  - `s == btnOut`: clear `dcnt`. Any bounce shorter than STABLE cycles is therefore invisible.
- **Hold counter:**
  - While `btnOut == 1`, `hcnt` increments.
  - When `hcnt == LONG-1`, assert `btnLong` for one cycle, set `btnHeld`, and saturate `hcnt` (no further `btnLong` pulses).
  - When `btnOut` falls, clear `hcnt` and `btnHeld`.
- **Release priority:** if `btnOut` falls at the same edge where `hcnt` would reach the long threshold, `btnRelease` pulses and `btnLong` stays 0.
- **Widths:** `dcnt` is `$clog2(STABLE)` bits and `hcnt` is `$clog2(LONG)` bits. Neither counter ever wraps.
- **Button held through reset:** after reset deassertion this is accepted as a normal press after the full latency below.

## Timing
- `btnIn` settles before edge k and stays stable → `btnOut`, `btnPress` and `btnRelease` update after edge k + SYNC_STAGES + STABLE − 1.
- `btnOut` rises after edge m → `btnLong` pulse and `btnHeld` rise after edge m + LONG.
- All outputs are registered with no combinational path from `btnIn`. Every strobe is exactly one cycle wide.
- `btnPress` and `btnRelease` of one channel are never asserted together.
- Minimum spacing between a channel's press and release strobes is STABLE cycles.

## Structure
- Shared package or include `debounce_pkg`:
  - Default timing constants DB_STABLE_5MS and DB_LONG_500MS, derived from CLK_HZ = 50_000_000.
  - SYNC_STAGES default.
- Sub-module `debounce_chan`: one channel, containing the synchroniser, `dcnt`, `hcnt` and output registers.
  - Instantiated N times with a generate loop.
  - Top level only slices the buses.

## Test plan
Bench parameters: N=4, STABLE=4, LONG=10, SYNC_STAGES=2, ACTIVE_LOW=0 unless noted.

- **Reset:** rst_n=0 with btnIn=4'hF → all outputs 0. Release rst_n before edge k → btnOut=4'hF and btnPress=4'hF for one cycle after edge k+5.
- **Clean press:** btnIn[0] 0→1 before edge k → btnOut[0]=1 and btnPress[0] one-cycle pulse after edge k+5; other bits stay 0.
- **Bounce:** btnIn[1] toggles every 3 cycles for 30 cycles, then holds 1 → no strobes during the bounce; one btnPress[1] 5 cycles after the final change.
- **Long press:** hold ch2; btnOut[2] rises after edge m → btnLong[2] pulses once after edge m+10 and btnHeld[2]=1. Releasing gives btnRelease[2], then btnHeld[2]=0 at the same edge as btnOut[2] falls.
- **Release vs long:** time the release so btnOut[2] falls at edge m+10 → btnLong[2] stays 0, btnRelease[2] pulses, btnHeld[2] stays 0.
- **Active-low mode and mid-count reset:**
  - ACTIVE_LOW=1 with btnIn idle at 4'hF; drive btnIn[3]=0 → btnOut[3]=1 after 5 edges.
  - Pulse rst_n low at count 2 → outputs 0 immediately; after rst_n returns high, a full 5-edge latency applies again.
